// File: rtl/psum_accum_pkg.sv
// Shared defaults and helpers for the multi-channel partial-sum accumulator bank.
package psum_accum_pkg;

  localparam int N_CH_D      = 8;
  localparam int DEPTH_D     = 16;
  localparam int IN_BITS_D   = 20;
  localparam int ACC_BITS_D  = 32;
  localparam int BIAS_BITS_D = 16;
  localparam int OUT_BITS_D  = 8;
  localparam int SHIFT_W_D   = 5;
  localparam int FIFO_D_D    = 4;
  localparam int SAT_CNT_W   = 16;

  // Counter add that sticks at all-ones instead of wrapping.
  function automatic logic [SAT_CNT_W-1:0] sat_add16(input logic [SAT_CNT_W-1:0] a,
                                                     input logic [SAT_CNT_W-1:0] b);
    logic [SAT_CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SAT_CNT_W] ? {SAT_CNT_W{1'b1}} : s[SAT_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/psum_requant.sv
// Per-channel requantiser: arithmetic right shift rounding toward zero, optional ReLU, saturation.
module psum_requant #(
  parameter int ACC_BITS = 32,
  parameter int SHIFT_W  = 5,
  parameter int OUT_BITS = 8
) (
  input  logic [ACC_BITS-1:0] i_acc,
  input  logic [SHIFT_W-1:0]  i_shift,
  input  logic                i_relu,
  output logic [OUT_BITS-1:0] o_res,
  output logic                o_sat
);

  localparam logic signed [ACC_BITS-1:0] MAX_V = ACC_BITS'((1 << (OUT_BITS-1)) - 1);
  localparam logic signed [ACC_BITS-1:0] MIN_V = ~MAX_V;

  logic        [ACC_BITS-1:0] mask;
  logic signed [ACC_BITS-1:0] shr;
  logic signed [ACC_BITS-1:0] val;

  always_comb begin
    mask = ~({ACC_BITS{1'b1}} << i_shift);
    shr  = $signed(i_acc) >>> i_shift;
    val  = shr;
    // Negative values with discarded ones were floored; step back toward zero.
    if (i_acc[ACC_BITS-1] && ((i_acc & mask) != '0)) val = shr + ACC_BITS'(1);
    if (i_relu && val[ACC_BITS-1]) val = '0;
    o_sat = 1'b0;
    o_res = val[OUT_BITS-1:0];
    if (val > MAX_V) begin
      o_res = MAX_V[OUT_BITS-1:0];
      o_sat = 1'b1;
    end else if (val < MIN_V) begin
      o_res = MIN_V[OUT_BITS-1:0];
      o_sat = 1'b1;
    end
  end

endmodule

// File: rtl/psum_accum_bank.sv
// Multi-channel psum accumulator bank with bias, requantise pipeline and credit-gated output FIFO.
module psum_accum_bank
  import psum_accum_pkg::*;
#(
  parameter int N_CH      = N_CH_D,
  parameter int DEPTH     = DEPTH_D,
  parameter int IN_BITS   = IN_BITS_D,
  parameter int ACC_BITS  = ACC_BITS_D,
  parameter int BIAS_BITS = BIAS_BITS_D,
  parameter int OUT_BITS  = OUT_BITS_D,
  parameter int SHIFT_W   = SHIFT_W_D,
  parameter int FIFO_D    = FIFO_D_D
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SHIFT_W-1:0]           i_cfg_shift,
  input  logic                         i_cfg_relu,
  input  logic                         i_sat_clr,
  input  logic                         i_in_vld,
  output logic                         o_in_rdy,
  input  logic [$clog2(DEPTH)-1:0]     i_in_addr,
  input  logic                         i_in_first,
  input  logic                         i_in_last,
  input  logic [N_CH*IN_BITS-1:0]      i_psum,
  input  logic [N_CH*BIAS_BITS-1:0]    i_bias,
  output logic                         o_out_vld,
  input  logic                         i_out_rdy,
  output logic [$clog2(DEPTH)-1:0]     o_out_addr,
  output logic [N_CH*OUT_BITS-1:0]     o_out_data,
  output logic [SAT_CNT_W-1:0]         o_sat_cnt,
  output logic                         o_busy
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = $clog2(FIFO_D);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ENT_W  = ADDR_W + N_CH*OUT_BITS;
  localparam int INC_W  = $clog2(N_CH+1);

  logic [N_CH*ACC_BITS-1:0] bank_q [DEPTH];
  logic [N_CH*ACC_BITS-1:0] acc_new;
  logic [N_CH*ACC_BITS-1:0] s1_sum;
  logic                     accept;
  logic [CNT_W:0]           pending;

  logic                     s1_vld_q;
  logic [ADDR_W-1:0]        s1_addr_q;
  logic [N_CH*ACC_BITS-1:0] s1_data_q;
  logic [SHIFT_W-1:0]       s1_shift_q;
  logic                     s1_relu_q;

  logic                     s2_vld_q;
  logic [ADDR_W-1:0]        s2_addr_q;
  logic [N_CH*OUT_BITS-1:0] s2_data_q;
  logic [N_CH*OUT_BITS-1:0] rq_data;
  logic [N_CH-1:0]          rq_sat;

  logic [INC_W-1:0]         sat_inc;
  logic [SAT_CNT_W-1:0]     sat_cnt_q, sat_cnt_d;

  logic [ENT_W-1:0]         fifo_mem_q [FIFO_D];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         fifo_cnt_q, fifo_cnt_d;
  logic                     push, pop;

  // Every result in flight already owns a FIFO slot, so the FIFO can never overflow.
  assign pending  = (CNT_W+1)'(fifo_cnt_q) + (CNT_W+1)'(s1_vld_q) + (CNT_W+1)'(s2_vld_q);
  assign o_in_rdy = pending < (CNT_W+1)'(FIFO_D);
  assign accept   = i_in_vld & o_in_rdy;

  always_comb begin
    acc_new = '0;
    s1_sum  = '0;
    for (int c = 0; c < N_CH; c++) begin
      acc_new[c*ACC_BITS +: ACC_BITS] = ACC_BITS'($signed(i_psum[c*IN_BITS +: IN_BITS]))
          + (i_in_first ? '0 : bank_q[i_in_addr][c*ACC_BITS +: ACC_BITS]);
      s1_sum[c*ACC_BITS +: ACC_BITS] = acc_new[c*ACC_BITS +: ACC_BITS]
          + ACC_BITS'($signed(i_bias[c*BIAS_BITS +: BIAS_BITS]));
    end
  end

  always_ff @(posedge clk) begin
    if (accept) bank_q[i_in_addr] <= acc_new;
  end

  always_ff @(posedge clk) begin
    if (accept && i_in_last) begin
      s1_addr_q  <= i_in_addr;
      s1_data_q  <= s1_sum;
      s1_shift_q <= i_cfg_shift;
      s1_relu_q  <= i_cfg_relu;
    end
    if (s1_vld_q) begin
      s2_addr_q <= s1_addr_q;
      s2_data_q <= rq_data;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_rq
    psum_requant #(
      .ACC_BITS (ACC_BITS),
      .SHIFT_W  (SHIFT_W),
      .OUT_BITS (OUT_BITS)
    ) u_rq (
      .i_acc   (s1_data_q[c*ACC_BITS +: ACC_BITS]),
      .i_shift (s1_shift_q),
      .i_relu  (s1_relu_q),
      .o_res   (rq_data[c*OUT_BITS +: OUT_BITS]),
      .o_sat   (rq_sat[c])
    );
  end

  always_comb begin
    sat_inc = '0;
    if (s1_vld_q) begin
      for (int c = 0; c < N_CH; c++) sat_inc = sat_inc + INC_W'(rq_sat[c]);
    end
    sat_cnt_d = sat_add16(i_sat_clr ? '0 : sat_cnt_q, SAT_CNT_W'(sat_inc));
  end

  assign push       = s2_vld_q;
  assign pop        = o_out_vld & i_out_rdy;
  assign fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      sat_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      s1_vld_q   <= accept & i_in_last;
      s2_vld_q   <= s1_vld_q;
      sat_cnt_q  <= sat_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {s2_addr_q, s2_data_q};
  end

  assign o_out_vld                = fifo_cnt_q != '0;
  assign {o_out_addr, o_out_data} = o_out_vld ? fifo_mem_q[rd_ptr_q] : '0;
  assign o_sat_cnt                = sat_cnt_q;
  assign o_busy                   = s1_vld_q | s2_vld_q | o_out_vld;

endmodule

// File: tb/tb_psum_accum_bank.sv
// Directed bench for psum_accum_bank: windows, rounding, saturation, backpressure, reset.
module tb_psum_accum_bank;

  logic        clk;
  logic        rst_n;
  logic [4:0]  i_cfg_shift;
  logic        i_cfg_relu;
  logic        i_sat_clr;
  logic        i_in_vld;
  logic        o_in_rdy;
  logic [3:0]  i_in_addr;
  logic        i_in_first;
  logic        i_in_last;
  logic [159:0] i_psum;
  logic [127:0] i_bias;
  logic        o_out_vld;
  logic        i_out_rdy;
  logic [3:0]  o_out_addr;
  logic [63:0] o_out_data;
  logic [15:0] o_sat_cnt;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  int acc_cnt;
  logic took;

  psum_accum_bank dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cfg_shift (i_cfg_shift),
    .i_cfg_relu  (i_cfg_relu),
    .i_sat_clr   (i_sat_clr),
    .i_in_vld    (i_in_vld),
    .o_in_rdy    (o_in_rdy),
    .i_in_addr   (i_in_addr),
    .i_in_first  (i_in_first),
    .i_in_last   (i_in_last),
    .i_psum      (i_psum),
    .i_bias      (i_bias),
    .o_out_vld   (o_out_vld),
    .i_out_rdy   (i_out_rdy),
    .o_out_addr  (o_out_addr),
    .o_out_data  (o_out_data),
    .o_sat_cnt   (o_sat_cnt),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input int addr, input bit first, input bit last,
                          input int p0, input int p1, input int b0, input int b1);
    i_in_vld   = 1'b1;
    i_in_addr  = 4'(addr);
    i_in_first = first;
    i_in_last  = last;
    i_psum     = '0;
    i_psum[19:0]  = 20'(p0);
    i_psum[39:20] = 20'(p1);
    i_bias     = '0;
    i_bias[15:0]  = 16'(b0);
    i_bias[31:16] = 16'(b1);
  endtask

  task automatic send(input int addr, input bit first, input bit last,
                      input int p0, input int p1, input int b0, input int b1);
    set_beat(addr, first, last, p0, p1, b0, b1);
    @(negedge clk);
  endtask

  task automatic idle();
    i_in_vld   = 1'b0;
    i_in_first = 1'b0;
    i_in_last  = 1'b0;
  endtask

  // Waits (bounded) for a result, then compares address and data at the head.
  task automatic chk_out(input string tag, input int addr, input logic [63:0] data);
    int n;
    n = 0;
    while (!o_out_vld && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!o_out_vld) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=no_output expected=output", tag);
    end else begin
      chk({tag, "_addr"}, 64'(o_out_addr), 64'(addr));
      chk({tag, "_data"}, o_out_data, data);
    end
  endtask

  initial begin
    rst_n = 1'b0; i_cfg_shift = '0; i_cfg_relu = 1'b0; i_sat_clr = 1'b0;
    i_out_rdy = 1'b1; i_psum = '0; i_bias = '0; i_in_addr = '0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_out_vld", 64'(o_out_vld), 64'd0);
    chk("rst_busy",    64'(o_busy),    64'd0);
    chk("rst_in_rdy",  64'(o_in_rdy),  64'd1);
    chk("rst_sat_cnt", 64'(o_sat_cnt), 64'd0);
    chk("rst_data",    o_out_data,     64'd0);

    // Single window with exact latency: ch0 256>>>2=64, ch1 54>>>2=13
    i_cfg_shift = 5'd2;
    send(3, 1, 0, 100, 10, 0, 0);
    send(3, 0, 0, 200, 20, 0, 0);
    send(3, 0, 1, -50, 30, 6, -6);
    idle();
    chk("lat_t0", 64'(o_out_vld), 64'd0);
    @(negedge clk);
    chk("lat_t1", 64'(o_out_vld), 64'd0);
    @(negedge clk);
    chk("lat_t2", 64'(o_out_vld), 64'd1);
    chk("win_addr", 64'(o_out_addr), 64'd3);
    chk("win_data", o_out_data, 64'h0D40);
    @(negedge clk);
    chk("win_drained_vld",  64'(o_out_vld), 64'd0);
    chk("win_drained_busy", 64'(o_busy),    64'd0);

    // Round toward zero: -7>>>1 -> -3, 7>>>1 -> 3; shift 0 passes through
    i_cfg_shift = 5'd1;
    send(0, 1, 1, -7, 7, 0, 0);
    idle();
    chk_out("rnd_s1", 0, 64'h03FD);
    @(negedge clk);
    i_cfg_shift = 5'd0;
    send(0, 1, 1, -7, 5, 0, 0);
    idle();
    chk_out("rnd_s0", 0, 64'h05F9);
    @(negedge clk);

    // Saturation both ways, then relu suppresses the negative clip
    send(1, 1, 1, 1000, -1000, 0, 0);
    idle();
    chk_out("sat", 1, 64'h807F);
    chk("sat_cnt2", 64'(o_sat_cnt), 64'd2);
    @(negedge clk);
    i_cfg_relu = 1'b1;
    send(1, 1, 1, -1000, 50, 0, 0);
    idle();
    chk_out("relu", 1, 64'h3200);
    chk("relu_sat_cnt", 64'(o_sat_cnt), 64'd2);
    @(negedge clk);
    i_cfg_relu = 1'b0;

    // Clear coinciding with a saturating result leaves only that increment
    send(1, 1, 1, 1000, 0, 0, 0);
    idle();
    i_sat_clr = 1'b1;
    @(negedge clk);
    i_sat_clr = 1'b0;
    chk("clr_same_cycle", 64'(o_sat_cnt), 64'd1);
    chk_out("clr_res", 1, 64'h007F);
    @(negedge clk);

    // Backpressure: six single-beat windows offered, four fit
    i_out_rdy = 1'b0;
    acc_cnt = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (acc_cnt < 6) set_beat(acc_cnt, 1, 1, acc_cnt + 1, 0, 0, 0);
      else idle();
      took = i_in_vld & o_in_rdy;
      @(negedge clk);
      if (took) acc_cnt++;
    end
    idle();
    chk("bp_accepted", 64'(acc_cnt), 64'd4);
    chk("bp_in_rdy",   64'(o_in_rdy), 64'd0);
    chk("bp_busy",     64'(o_busy),   64'd1);
    i_out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_order_vld",  64'(o_out_vld),  64'd1);
      chk("bp_order_addr", 64'(o_out_addr), 64'(k));
      chk("bp_order_data", o_out_data,      64'(k + 1));
      @(negedge clk);
    end
    chk("bp_empty", 64'(o_out_vld), 64'd0);

    // Interleaved addresses and back-to-back same-address beats
    i_out_rdy = 1'b0;
    send(0, 1, 0, 10, 1, 0, 0);
    send(1, 1, 0, 20, 2, 0, 0);
    send(0, 0, 0, 5, 1, 0, 0);
    send(1, 0, 0, -3, 2, 0, 0);
    send(0, 0, 1, 1, 1, 0, 0);
    send(1, 0, 1, 2, 2, 0, 0);
    send(2, 1, 0, 3, 0, 0, 0);
    send(2, 0, 0, 4, 0, 0, 0);
    send(2, 0, 1, 5, 0, 0, 0);
    idle();
    repeat (3) @(negedge clk);
    i_out_rdy = 1'b1;
    chk_out("ilv_a0", 0, 64'h0310);
    @(negedge clk);
    chk_out("ilv_a1", 1, 64'h0613);
    @(negedge clk);
    chk_out("ilv_a2", 2, 64'h000C);
    @(negedge clk);

    // Reset with two results queued
    i_out_rdy = 1'b0;
    send(5, 1, 1, 1000, 0, 0, 0);
    send(6, 1, 1, 3, 0, 0, 0);
    idle();
    repeat (3) @(negedge clk);
    chk("pre_rst_vld", 64'(o_out_vld), 64'd1);
    chk("pre_rst_sat", 64'(o_sat_cnt), 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_vld",  64'(o_out_vld), 64'd0);
    chk("mid_rst_busy", 64'(o_busy),    64'd0);
    chk("mid_rst_sat",  64'(o_sat_cnt), 64'd0);
    chk("mid_rst_rdy",  64'(o_in_rdy),  64'd1);
    i_out_rdy = 1'b1;

    // Bank contents survive reset: addr2 held 12
    send(2, 0, 1, 1, 0, 0, 0);
    idle();
    chk_out("bank_keep", 2, 64'h000D);
    @(negedge clk);
    chk("final_idle", 64'(o_busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
